// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch FSM state encoding (IDLE / REQ / DRAIN)
//   - NOP instruction value presented when no instruction is available
//   - PC step between sequential fetches
//   - fetch buffer depth and entry layout
package fetch_unit_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;  // no request outstanding
    localparam logic [1:0] ST_REQ   = 2'd1;  // request outstanding, data will be kept
    localparam logic [1:0] ST_DRAIN = 2'd2;  // request outstanding, data will be dropped

    localparam logic [31:0] NOP_INSTR = 32'd0;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Fetch buffer depth, sized to match the 2-bit occupancy count
    localparam logic [1:0] BUF_DEPTH = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_incr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf
// Two-entry FIFO holding fetched {instr, pc_incr} pairs.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-low reset (empties the FIFO)
//   i_push   - write i_wdata at the tail (ignored when full)
//   i_pop    - drop the head entry (ignored when empty)
//   i_flush  - discard all entries; overrides push and pop
//   i_wdata  - entry to write
//   o_count  - number of valid entries (0..2)
//   o_empty  - no valid entries
//   o_head   - head entry, all-zero (NOP/0) when empty
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wdata,
    output logic [1:0]   o_count,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_full;
    logic         w_do_push;
    logic         w_do_pop;
    fetch_entry_t w_entries [2];

    assign w_full    = (r_count == BUF_DEPTH);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;

    // One storage register per slot; only the slot under the write pointer loads.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
        fetch_entry_t r_entry;

        always_ff @(posedge clk) begin
            if (w_do_push && !i_flush && (r_wr_ptr == gi[0])) begin
                r_entry <= i_wdata;
            end
        end

        assign w_entries[gi] = r_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_count = r_count;
    assign o_head  = o_empty ? '{instr: NOP_INSTR, pc_incr: 32'd0} : w_entries[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: keeps the PC, issues word requests to instruction
// memory, buffers up to two returned instructions and presents the head one
// to the IF/ID register.
// Ports:
//   clk          - clock
//   rst          - asynchronous active-low reset
//   lock         - IF/ID stall; head instruction is not consumed while 1
//   redirect     - taken branch/jump pulse; flushes buffer, reloads PC
//   redirect_pc  - new fetch address, valid with redirect
//   imem_req     - instruction memory request
//   imem_addr    - address of the current request
//   imem_ack     - imem_rdata valid for the current request
//   imem_rdata   - returned instruction word
//   Out_instr    - instruction to IF/ID, NOP when none is available
//   Out_pc_incr  - fetch address + 4 of Out_instr, 0 when none is available
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lock,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Out_instr,
    output logic [31:0] Out_pc_incr
);

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_incr;
    logic [1:0]   w_count;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;
    logic [2:0]   w_fill_after;
    fetch_entry_t w_wdata;
    fetch_entry_t w_head;

    // Redirect wins over both the stall and a returning acknowledge.
    assign w_pop     = !lock && !w_empty && !redirect;
    assign w_push    = (r_state == ST_REQ) && imem_ack && !redirect;
    assign w_pc_incr = r_pc + PC_STEP;  // wraps modulo 2^32
    assign w_wdata   = '{instr: imem_rdata, pc_incr: w_pc_incr};

    // Occupancy after this edge's push and pop; decides whether another
    // request may be issued without overrunning the buffer.
    assign w_fill_after = {1'b0, w_count} + 3'd1 - {2'b00, w_pop};

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (redirect) begin
            w_pc_next = redirect_pc;
            case (r_state)
                ST_IDLE:  w_state_next = ST_REQ;
                // An unacknowledged request is still in flight and its data
                // must be thrown away once it arrives.
                ST_REQ,
                ST_DRAIN: w_state_next = imem_ack ? ST_REQ : ST_DRAIN;
                default:  w_state_next = ST_REQ;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((w_count < BUF_DEPTH) || w_pop) begin
                        w_state_next = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        w_pc_next    = w_pc_incr;
                        w_state_next = (w_fill_after < {1'b0, BUF_DEPTH}) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        w_state_next = ST_REQ;
                    end
                end
                default: w_state_next = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata (w_wdata),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign imem_req    = (r_state != ST_IDLE);
    assign imem_addr   = r_pc;
    assign Out_instr   = w_head.instr;
    assign Out_pc_incr = w_head.pc_incr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed-vector bench for fetch_unit. A small memory model answers requests
// either automatically (rdata = addr | A000_0000 after ack_delay wait cycles)
// or under direct control (man_ack / man_rdata).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lock = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Out_instr;
    logic [31:0] Out_pc_incr;

    logic        auto_mode = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'd0;

    int n_vec = 0;
    int n_err = 0;
    int fetches;

    logic [31:0] exp_a_addr  [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    logic [31:0] exp_a_instr [6] = '{32'h0, 32'hA000_0000, 32'hA000_0004,
                                     32'hA000_0008, 32'hA000_000C, 32'hA000_0010};
    logic [31:0] exp_a_inc   [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    logic [31:0] exp_c_instr [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA000_0000,
                                     32'h0, 32'h0, 32'h0, 32'hA000_0004};
    logic [31:0] exp_c_addr  [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4,
                                     32'h4, 32'h4, 32'h4, 32'h8};

    always #5 clk = ~clk;

    assign imem_ack   = auto_mode ? (imem_req && (wait_cnt >= ack_delay)) : man_ack;
    assign imem_rdata = auto_mode ? (imem_addr | 32'hA000_0000) : man_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst)                     wait_cnt <= 0;
        else if (imem_req && imem_ack) wait_cnt <= 0;
        else if (imem_req)            wait_cnt <= wait_cnt + 1;
    end

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .lock        (lock),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Out_instr   (Out_instr),
        .Out_pc_incr (Out_pc_incr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, release just after an edge.
    task automatic do_reset();
        rst = 1'b0;
        lock = 1'b0;
        redirect = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---- reset values and zero-wait streaming ----
        auto_mode = 1'b1;
        ack_delay = 0;
        rst = 1'b0;
        step();
        chk("rst_instr", Out_instr, 32'h0);
        chk("rst_pcinc", Out_pc_incr, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        step();
        rst = 1'b1;
        chk("rel_req", {31'd0, imem_req}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("stream_addr%0d", k), imem_addr, exp_a_addr[k]);
            chk($sformatf("stream_instr%0d", k), Out_instr, exp_a_instr[k]);
            chk($sformatf("stream_pcinc%0d", k), Out_pc_incr, exp_a_inc[k]);
            step();
        end

        // ---- lock for 5 cycles: two fetches fill the buffer, then idle ----
        do_reset();
        lock = 1'b1;
        fetches = 0;
        for (int k = 0; k < 5; k++) begin
            if (imem_req && imem_ack) fetches++;
            chk($sformatf("lock_instr%0d", k), Out_instr, (k == 0) ? 32'h0 : 32'hA000_0000);
            chk($sformatf("lock_req%0d", k), {31'd0, imem_req}, (k < 2) ? 32'h1 : 32'h0);
            step();
        end
        chk("lock_fetches", fetches, 32'd2);
        lock = 1'b0;
        chk("unlock_instr0", Out_instr, 32'hA000_0000);
        step();
        chk("unlock_instr1", Out_instr, 32'hA000_0004);
        chk("unlock_addr1", imem_addr, 32'h8);
        step();
        chk("unlock_instr2", Out_instr, 32'hA000_0008);
        chk("unlock_addr2", imem_addr, 32'hC);

        // ---- three wait cycles per request ----
        ack_delay = 3;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("wait_instr%0d", k), Out_instr, exp_c_instr[k]);
            chk($sformatf("wait_addr%0d", k), imem_addr, exp_c_addr[k]);
            step();
        end
        ack_delay = 0;

        // ---- redirect while request to 0x20 outstanding ----
        auto_mode = 1'b0;
        man_ack = 1'b0;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        chk("rd_drain_addr", imem_addr, 32'h20);
        man_ack = 1'b1;
        man_rdata = 32'hDEAD_0000;
        step();
        man_ack = 1'b0;
        chk("rd_req_addr20", imem_addr, 32'h20);
        chk("rd_instr_a", Out_instr, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("rd_addr100", imem_addr, 32'h100);
        chk("rd_req_drain", {31'd0, imem_req}, 32'h1);
        man_ack = 1'b1;
        man_rdata = 32'hDEAD_0020;
        step();
        chk("rd_discard_instr", Out_instr, 32'h0);
        chk("rd_addr100_b", imem_addr, 32'h100);
        man_rdata = 32'hA000_0100;
        step();
        man_ack = 1'b0;
        chk("rd_instr100", Out_instr, 32'hA000_0100);
        chk("rd_pcinc100", Out_pc_incr, 32'h104);
        chk("rd_addr104", imem_addr, 32'h104);

        // ---- redirect with ack and lock while buffer full ----
        auto_mode = 1'b1;
        do_reset();
        lock = 1'b1;
        step();
        step();
        chk("full_req", {31'd0, imem_req}, 32'h0);
        chk("full_instr", Out_instr, 32'hA000_0000);
        auto_mode = 1'b0;
        man_ack = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        man_ack = 1'b0;
        auto_mode = 1'b1;
        lock = 1'b0;
        chk("flush_instr", Out_instr, 32'h0);
        chk("flush_pcinc", Out_pc_incr, 32'h0);
        chk("flush_addr", imem_addr, 32'h200);
        chk("flush_req", {31'd0, imem_req}, 32'h1);
        step();
        chk("flush_next_instr", Out_instr, 32'hA000_0200);
        chk("flush_next_pcinc", Out_pc_incr, 32'h204);

        // ---- pc wrap at top of address space ----
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_instr", Out_instr, 32'hFFFF_FFFC);
        chk("wrap_pcinc", Out_pc_incr, 32'h0);
        chk("wrap_addr0", imem_addr, 32'h0);
        step();
        chk("wrap_next_instr", Out_instr, 32'hA000_0000);
        chk("wrap_next_pcinc", Out_pc_incr, 32'h4);

        // ---- reset asserted while draining ----
        auto_mode = 1'b0;
        man_ack = 1'b0;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        chk("drain_addr40", imem_addr, 32'h40);
        #2;
        rst = 1'b0;
        man_ack = 1'b1;
        man_rdata = 32'hBAD0_0000;
        #1;
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_instr", Out_instr, 32'h0);
        chk("arst_req", {31'd0, imem_req}, 32'h1);
        step();
        step();
        man_ack = 1'b0;
        rst = 1'b1;
        chk("arel_addr", imem_addr, 32'h0);
        chk("arel_instr", Out_instr, 32'h0);
        man_ack = 1'b1;
        man_rdata = 32'hC0DE_0000;
        step();
        man_ack = 1'b0;
        chk("arel_first_instr", Out_instr, 32'hC0DE_0000);
        chk("arel_first_pcinc", Out_pc_incr, 32'h4);
        step();
        chk("arel_empty_instr", Out_instr, 32'h0);
        chk("arel_addr4", imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 lock  input  1  stall from hazard unit; 1 = downstream IF/ID holds, no instruction consumed this cycle.
REQ-005 redirect  input  1  branch/jump taken; single-cycle pulse.
REQ-006 redirect_pc  input  32  target address, valid when redirect=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  word address of the current request.
REQ-009 imem_ack  input  1  imem_rdata valid for the current request this cycle; 0..N wait cycles.
REQ-010 imem_rdata  input  32  fetched instruction.
REQ-011 Out_instr  output  32  instruction presented to IF/ID; 32'd0 (NOP) when none available.
REQ-012 Out_pc_incr  output  32  fetch address + 4 of Out_instr; 32'd0 when none available.

Function
REQ-013 Fetch buffer: 2-entry FIFO of {instr, pc_incr}; Out_instr/Out_pc_incr driven combinationally from head, NOP/0 when empty.
REQ-014 Pop occurs at a clock edge where lock=0, FIFO non-empty, redirect=0; lock=0 with empty FIFO is a bubble (IF/ID captures 0/0).
REQ-015 States: IDLE (no request), REQ (request outstanding), DRAIN (request outstanding whose data is discarded).
REQ-016 imem_req = 1 in REQ and DRAIN, 0 in IDLE; imem_addr = pc register; request and address held stable until imem_ack.
REQ-017 REQ with imem_ack=1, redirect=0: push {imem_rdata, pc+4}, pc <= pc+4; next state REQ if count+1-pop < 2, else IDLE.
REQ-018 IDLE with redirect=0: go to REQ when count < 2 or a pop occurs this edge; otherwise stay IDLE.
REQ-019 Invariant: FIFO count + outstanding request <= 2; push into a full FIFO never occurs.
REQ-020 redirect=1 (any state): FIFO flushed, pc <= redirect_pc, no pop that edge; redirect has priority over lock and imem_ack.
REQ-021 redirect in REQ with imem_ack=0 -> DRAIN; with imem_ack=1 -> data discarded, next state REQ at redirect_pc.
REQ-022 redirect in IDLE -> REQ at redirect_pc; redirect in DRAIN -> pc updated again, stays DRAIN (or REQ if imem_ack=1 that cycle).
REQ-023 DRAIN with imem_ack=1: data discarded, no push, next state REQ at current pc.
REQ-024 pc arithmetic 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-025 Zero-wait memory (imem_ack=1 every cycle) with lock=0 sustains one instruction per cycle after initial fill.

Reset
REQ-026 rst=0 asynchronously forces: pc=RESET_PC, FIFO empty, state REQ, Out_instr=0, Out_pc_incr=0; imem_req=1 with imem_addr=RESET_PC from first cycle after rst releases.
REQ-027 rst asserted mid-request abandons it; any imem_ack received during reset is ignored.

Structure
REQ-028 Shared package holds state encoding (IDLE/REQ/DRAIN), NOP constant 32'd0, PC step constant 4.
REQ-029 Sub-module fetch_buf (2-deep FIFO with push, pop, flush, count, head outputs); FSM and pc register remain in fetch_unit.

Verification
REQ-030 Reset release, RESET_PC=0, imem_ack=1 always, lock=0, imem_rdata=addr|32'hA000_0000 -> imem_addr 0,4,8,...; Out_instr 0 first cycle, then A000_0000, A000_0004,... with Out_pc_incr 4, 8, ....
REQ-031 lock=1 for 5 cycles during streaming -> exactly 2 fetches complete, then imem_req=0; Out_instr held; lock=0 resumes with no instruction lost or duplicated.
REQ-032 imem_ack delayed 3 cycles per request -> imem_addr stable across waits; one bubble (0/0) per wait cycle at Out_instr.
REQ-033 redirect, redirect_pc=32'h100, while request to 32'h20 outstanding -> DRAIN; data for 32'h20 discarded; next request 32'h100; Out_instr 0 until data for 32'h100 arrives.
REQ-034 redirect coincident with imem_ack and lock=1, FIFO full -> FIFO empty next cycle, pc=redirect_pc, state REQ.
REQ-035 rst=0 asserted while in DRAIN -> outputs 0 immediately; after release first imem_addr=RESET_PC.
